// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory sequencer.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_CANCEL = 3'd4
  } state_e;

endpackage

// File: rtl/mem_resp_buf.sv
// Load-result holding register: clear beats load, otherwise it holds its value.
module mem_resp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] buf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      buf_q <= '0;
    end else if (ld_i) begin
      buf_q <= d_i;
    end
  end

  assign q_o = buf_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-port sequencer: issues bus request/addr_ok/data_ok transactions,
// stalls the pipeline until each resolves, and drains flushed transactions.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_req_valid_i,
  input  logic                mem_wr_i,
  input  logic [1:0]          mem_size_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  input  logic                pipe_stall_i,
  input  logic                flush_i,
  output logic                data_req_o,
  output logic                data_wr_o,
  output logic [1:0]          data_size_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  output logic [DATA_W/8-1:0] data_wstrb_o,
  input  logic                data_addr_ok_i,
  input  logic                data_data_ok_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  output logic                stall_req_o,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o
);

  state_e              state_q;
  logic                data_req_q;
  logic                data_wr_q;
  logic [1:0]          data_size_q;
  logic [ADDR_W-1:0]   data_addr_q;
  logic [DATA_W-1:0]   data_wdata_q;
  logic [DATA_W/8-1:0] data_wstrb_q;
  logic                resp_valid_q;
  logic                addr_pending_q;
  logic                data_pending_q;

  logic                buf_ld;
  logic [DATA_W-1:0]   buf_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      data_req_q     <= 1'b0;
      data_wr_q      <= 1'b0;
      data_size_q    <= '0;
      data_addr_q    <= '0;
      data_wdata_q   <= '0;
      data_wstrb_q   <= '0;
      resp_valid_q   <= 1'b0;
      addr_pending_q <= 1'b0;
      data_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req_valid_i && !flush_i) begin
            data_wr_q    <= mem_wr_i;
            data_size_q  <= mem_size_i;
            data_addr_q  <= mem_addr_i;
            data_wdata_q <= mem_wdata_i;
            data_wstrb_q <= mem_wstrb_i;
            data_req_q   <= 1'b1;
            state_q      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (flush_i) begin
            // The request cannot be withdrawn; remember whether its handshake is still owed.
            state_q        <= ST_CANCEL;
            data_pending_q <= 1'b1;
            addr_pending_q <= !data_addr_ok_i;
            if (data_addr_ok_i) begin
              data_req_q <= 1'b0;
            end
          end else if (data_addr_ok_i) begin
            data_req_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            if (data_data_ok_i) begin
              state_q <= ST_IDLE;
            end else begin
              state_q        <= ST_CANCEL;
              addr_pending_q <= 1'b0;
              data_pending_q <= 1'b1;
            end
          end else if (data_data_ok_i) begin
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (flush_i || !pipe_stall_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_CANCEL: begin
          if (addr_pending_q) begin
            if (data_addr_ok_i) begin
              addr_pending_q <= 1'b0;
              data_req_q     <= 1'b0;
            end
          end else if (data_pending_q && data_data_ok_i) begin
            data_pending_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          data_req_q   <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_req_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE:   stall_req_o = mem_req_valid_i && !flush_i;
        ST_ADDR,
        ST_WAIT,
        ST_CANCEL: stall_req_o = 1'b1;
        default:   stall_req_o = 1'b0;
      endcase
    end
  end

  assign buf_ld = (state_q == ST_WAIT) && data_data_ok_i && !flush_i;
  assign buf_d  = data_wr_q ? '0 : data_rdata_i;

  mem_resp_buf #(
    .DATA_W (DATA_W)
  ) u_resp_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .ld_i  (buf_ld),
    .d_i   (buf_d),
    .q_o   (resp_rdata_o)
  );

  assign data_req_o   = data_req_q;
  assign data_wr_o    = data_wr_q;
  assign data_size_o  = data_size_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;
  assign data_wstrb_o = data_wstrb_q;
  assign resp_valid_o = resp_valid_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_valid_i;
  logic        mem_wr_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        pipe_stall_i;
  logic        flush_i;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_wstrb_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic        stall_req_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mem_req_valid_i (mem_req_valid_i),
    .mem_wr_i        (mem_wr_i),
    .mem_size_i      (mem_size_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_wstrb_i     (mem_wstrb_i),
    .pipe_stall_i    (pipe_stall_i),
    .flush_i         (flush_i),
    .data_req_o      (data_req_o),
    .data_wr_o       (data_wr_o),
    .data_size_o     (data_size_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_wstrb_o    (data_wstrb_o),
    .data_addr_ok_i  (data_addr_ok_i),
    .data_data_ok_i  (data_data_ok_i),
    .data_rdata_i    (data_rdata_i),
    .stall_req_o     (stall_req_o),
    .resp_valid_o    (resp_valid_o),
    .resp_rdata_o    (resp_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let combinational outputs settle after input changes.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb);
    mem_req_valid_i = 1'b1;
    mem_wr_i        = wr;
    mem_size_i      = 2'd2;
    mem_addr_i      = addr;
    mem_wdata_i     = wdata;
    mem_wstrb_i     = strb;
  endtask

  initial begin
    rst_i = 1'b1;
    mem_req_valid_i = 1'b1;
    mem_wr_i = 1'b0; mem_size_i = 2'd0; mem_addr_i = 32'h0;
    mem_wdata_i = 32'h0; mem_wstrb_i = 4'h0;
    pipe_stall_i = 1'b0; flush_i = 1'b0;
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;

    // reset state, stall_req forced low even with a request present
    cyc(); cyc();
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    rst_i = 1'b0; mem_req_valid_i = 1'b0;
    cyc();

    // T1 minimum-latency load
    req(1'b0, 32'h0000_0100, 32'h0, 4'h0); settle();
    chk("t1_c0_stall", {31'd0, stall_req_o}, 32'd1);
    chk("t1_c0_req", {31'd0, data_req_o}, 32'd0);
    cyc();
    data_addr_ok_i = 1'b1; settle();
    chk("t1_c1_req", {31'd0, data_req_o}, 32'd1);
    chk("t1_c1_addr", data_addr_o, 32'h0000_0100);
    chk("t1_c1_wr", {31'd0, data_wr_o}, 32'd0);
    chk("t1_c1_stall", {31'd0, stall_req_o}, 32'd1);
    cyc();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF; settle();
    chk("t1_c2_req", {31'd0, data_req_o}, 32'd0);
    chk("t1_c2_stall", {31'd0, stall_req_o}, 32'd1);
    chk("t1_c2_rv", {31'd0, resp_valid_o}, 32'd0);
    cyc();
    data_data_ok_i = 1'b0; mem_req_valid_i = 1'b0; settle();
    chk("t1_c3_rv", {31'd0, resp_valid_o}, 32'd1);
    chk("t1_c3_rdata", resp_rdata_o, 32'hDEAD_BEEF);
    chk("t1_c3_stall", {31'd0, stall_req_o}, 32'd0);
    cyc();
    chk("t1_c4_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("t1_c4_stall", {31'd0, stall_req_o}, 32'd0);

    // T2 store, addr_ok delayed; request fields must not follow changing inputs
    req(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF); settle();
    chk("t2_c0_stall", {31'd0, stall_req_o}, 32'd1);
    cyc();
    mem_addr_i = 32'hFFFF_FFFF; mem_wdata_i = 32'h0; mem_wstrb_i = 4'h0; mem_wr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok_i = (i == 3); settle();
      chk("t2_req", {31'd0, data_req_o}, 32'd1);
      chk("t2_wr", {31'd0, data_wr_o}, 32'd1);
      chk("t2_addr", data_addr_o, 32'h0000_1000);
      chk("t2_wdata", data_wdata_o, 32'h1234_5678);
      chk("t2_wstrb", {28'd0, data_wstrb_o}, 32'hF);
      chk("t2_size", {30'd0, data_size_o}, 32'd2);
      chk("t2_stall", {31'd0, stall_req_o}, 32'd1);
      cyc();
    end
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hAAAA_0000; settle();
    chk("t2_wait_req", {31'd0, data_req_o}, 32'd0);
    cyc();
    data_data_ok_i = 1'b0; mem_req_valid_i = 1'b0; settle();
    chk("t2_rv", {31'd0, resp_valid_o}, 32'd1);
    chk("t2_rdata", resp_rdata_o, 32'd0);
    cyc();
    chk("t2_rv_drop", {31'd0, resp_valid_o}, 32'd0);

    // T3 load completes under a 4-cycle downstream stall
    req(1'b0, 32'h0000_0200, 32'h0, 4'h0); cyc();
    data_addr_ok_i = 1'b1; cyc();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hCAFE_F00D; cyc();
    data_data_ok_i = 1'b0; data_rdata_i = 32'h9999_9999; mem_req_valid_i = 1'b0;
    pipe_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_hold_rv", {31'd0, resp_valid_o}, 32'd1);
      chk("t3_hold_rdata", resp_rdata_o, 32'hCAFE_F00D);
      chk("t3_hold_stall", {31'd0, stall_req_o}, 32'd0);
      cyc();
    end
    pipe_stall_i = 1'b0; settle();
    chk("t3_release_rv", {31'd0, resp_valid_o}, 32'd1);
    cyc();
    chk("t3_idle_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("t3_idle_rdata", resp_rdata_o, 32'hCAFE_F00D);

    // T4 flush in ADDR before addr_ok; transaction drained, then a clean load
    req(1'b0, 32'h0000_0300, 32'h0, 4'h0); cyc();
    flush_i = 1'b1; settle();
    chk("t4_flush_stall", {31'd0, stall_req_o}, 32'd1);
    cyc();
    flush_i = 1'b0; mem_req_valid_i = 1'b0; settle();
    chk("t4_c2_req", {31'd0, data_req_o}, 32'd1);
    chk("t4_c2_stall", {31'd0, stall_req_o}, 32'd1);
    chk("t4_c2_rdata", resp_rdata_o, 32'd0);
    cyc();
    data_addr_ok_i = 1'b1; settle();
    chk("t4_c3_req", {31'd0, data_req_o}, 32'd1);
    cyc();
    data_addr_ok_i = 1'b0; settle();
    chk("t4_c4_req", {31'd0, data_req_o}, 32'd0);
    chk("t4_c4_stall", {31'd0, stall_req_o}, 32'd1);
    cyc();
    data_data_ok_i = 1'b1; data_rdata_i = 32'h55AA_55AA; settle();
    chk("t4_c5_stall", {31'd0, stall_req_o}, 32'd1);
    chk("t4_c5_rv", {31'd0, resp_valid_o}, 32'd0);
    cyc();
    data_data_ok_i = 1'b0; settle();
    chk("t4_c6_stall", {31'd0, stall_req_o}, 32'd0);
    chk("t4_c6_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("t4_c6_rdata", resp_rdata_o, 32'd0);
    cyc();
    chk("t4_c7_rv", {31'd0, resp_valid_o}, 32'd0);
    req(1'b0, 32'h0000_0400, 32'h0, 4'h0); settle();
    chk("t4_next_stall", {31'd0, stall_req_o}, 32'd1);
    cyc();
    data_addr_ok_i = 1'b1; settle();
    chk("t4_next_addr", data_addr_o, 32'h0000_0400);
    cyc();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h0BAD_F00D; cyc();
    data_data_ok_i = 1'b0; mem_req_valid_i = 1'b0; settle();
    chk("t4_next_rv", {31'd0, resp_valid_o}, 32'd1);
    chk("t4_next_rdata", resp_rdata_o, 32'h0BAD_F00D);
    cyc();

    // T6 reset while waiting for data
    req(1'b0, 32'h0000_0500, 32'h0, 4'h0); cyc();
    data_addr_ok_i = 1'b1; cyc();
    data_addr_ok_i = 1'b0; rst_i = 1'b1; cyc();
    settle();
    chk("t6_req", {31'd0, data_req_o}, 32'd0);
    chk("t6_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("t6_rdata", resp_rdata_o, 32'd0);
    chk("t6_stall", {31'd0, stall_req_o}, 32'd0);
    chk("t6_addr", data_addr_o, 32'd0);
    rst_i = 1'b0; mem_req_valid_i = 1'b0; settle();
    chk("t6_idle_stall", {31'd0, stall_req_o}, 32'd0);
    cyc();

    // T5 flush coincides with data_ok
    req(1'b0, 32'h0000_0600, 32'h0, 4'h0); cyc();
    data_addr_ok_i = 1'b1; cyc();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h1111_2222;
    flush_i = 1'b1; mem_req_valid_i = 1'b0; settle();
    chk("t5_c2_stall", {31'd0, stall_req_o}, 32'd1);
    cyc();
    data_data_ok_i = 1'b0; flush_i = 1'b0; settle();
    chk("t5_c3_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("t5_c3_stall", {31'd0, stall_req_o}, 32'd0);
    chk("t5_c3_rdata", resp_rdata_o, 32'd0);
    cyc();
    chk("t5_c4_rv", {31'd0, resp_valid_o}, 32'd0);

    // T7 flush in WAIT before data_ok, with the next request waiting behind it
    req(1'b0, 32'h0000_0700, 32'h0, 4'h0); cyc();
    data_addr_ok_i = 1'b1; cyc();
    data_addr_ok_i = 1'b0; flush_i = 1'b1; cyc();
    flush_i = 1'b0; req(1'b0, 32'h0000_0800, 32'h0, 4'h0); settle();
    chk("t7_cancel_stall", {31'd0, stall_req_o}, 32'd1);
    chk("t7_cancel_req", {31'd0, data_req_o}, 32'd0);
    cyc();
    data_data_ok_i = 1'b1; data_rdata_i = 32'h3333_4444; settle();
    chk("t7_drain_rv", {31'd0, resp_valid_o}, 32'd0);
    cyc();
    data_data_ok_i = 1'b0; settle();
    chk("t7_idle_stall", {31'd0, stall_req_o}, 32'd1);
    chk("t7_idle_rv", {31'd0, resp_valid_o}, 32'd0);
    cyc();
    data_addr_ok_i = 1'b1; settle();
    chk("t7_next_req", {31'd0, data_req_o}, 32'd1);
    chk("t7_next_addr", data_addr_o, 32'h0000_0800);
    cyc();
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h7777_7777; cyc();
    data_data_ok_i = 1'b0; mem_req_valid_i = 1'b0; settle();
    chk("t7_next_rv", {31'd0, resp_valid_o}, 32'd1);
    chk("t7_next_rdata", resp_rdata_o, 32'h7777_7777);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
